wb_exception_unit: RTL and testbench
====================================

Name: wb_exception_unit

Overview:
- Parametrised writeback-stage controller for the 5-stage pipeline.
- Generates the register-file write-data select (LW selects memory data).
- Arbitrates synchronous exceptions from step 4 against N external interrupt lines.
- Captures EPC and cause into registers and sequences flush, vector, handler and return through an FSM.

Parameters:
- ADDR_W, 16, width of PC/EPC.
- CAUSE_W, 3, width of cause codes.
- N_IRQ, 4, number of external interrupt lines (1..8).
- MIN_EPC, 5, lowest PC at which an event is accepted; below this is the boot/vector region.
- VECTOR_ADDR, 4, handler entry address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  instruction in step 5 is valid.
- opcode  in  6  opcode of the step-5 instruction.
- wb_pc  in  ADDR_W  PC of the step-5 instruction (epc_addr_step4 pipelined).
- wb_cause  in  CAUSE_W  exception cause from step 4; CAUSE_NONE means no exception.
- irq_req  in  N_IRQ  level-sensitive external interrupt requests.
- irq_mask  in  N_IRQ  1 = line masked.
- mux_rf_wd_select  out  1  1 = write back memory data.
- flush  out  1  kill steps 1–4.
- pc_redirect  out  1  PC must load redirect_addr.
- redirect_addr  out  ADDR_W  target for pc_redirect.
- epc  out  ADDR_W  captured exception PC.
- cause_reg  out  CAUSE_W+? see Behaviour.
- in_handler  out  1  FSM is in HANDLER.
- irq_ack  out  N_IRQ  one-hot, one-cycle acknowledge of the taken line.

Behaviour:
- **Write-data select:** mux_rf_wd_select = (opcode == OPCODE_LW). Purely combinational and independent of FSM state.
- **Exception event:**
  - exc = wb_valid && wb_cause != CAUSE_NONE && wb_pc >= MIN_EPC && wb_pc != epc.
  - The wb_pc != epc term is duplicate suppression.
  - A wb_cause of CAUSE_SYSCALL bypasses duplicate suppression.
- **Interrupt event:** irq = wb_valid && |(irq_req & ~irq_mask) && wb_pc >= MIN_EPC.
- **Priority:**
  - exc beats irq.
  - Among IRQ lines, the lowest index wins.
- **cause_reg:** width is CAUSE_W+1.
  - MSB = 1 for an interrupt. Low bits = the winning IRQ index (zero-extended).
  - MSB = 0 for an exception. Low bits = wb_cause.
- **FSM states:** IDLE, FLUSH, HANDLER, RETURN. Encoding is in the package.
  - **IDLE:**
    - On exc or irq: latch epc <= wb_pc and cause_reg, pulse irq_ack for the winner (irq only), then go to FLUSH.
    - Otherwise stay in IDLE.
  - **FLUSH (exactly 1 cycle):** flush=1, pc_redirect=1, redirect_addr=VECTOR_ADDR, then go to HANDLER.
  - **HANDLER:**
    - in_handler=1. All exc/irq events are ignored (no nesting); epc and cause_reg hold.
    - On wb_valid && opcode == OPCODE_ERET, go to RETURN.
  - **RETURN (1 cycle):** flush=1, pc_redirect=1, then go to IDLE.
    - redirect_addr = epc when cause_reg MSB = 1 (re-execute the interrupted instruction).
    - redirect_addr = epc+1 otherwise (skip the faulting instruction). Wraps modulo 2^ADDR_W.
- **Output defaults:** flush, pc_redirect, irq_ack are 0 and redirect_addr is 0 in every state other than those above.
- **Reset:** state=IDLE; epc=0; cause_reg=0; all outputs 0. Applies mid-handler as well, and any pending return is abandoned.
- **Boundaries:**
  - An event in the same cycle as the ERET that leaves HANDLER is ignored.
  - An event arriving in RETURN is ignored.
  - The first event after reset with wb_pc == 0 is always suppressed, because MIN_EPC > 0.

Optional Feature:
- Macro: WB_IRQ_PENDING_LATCH_EN.
- **Defined:**
  - irq_req is sampled into a pending register on each rising edge: pending |= irq_req.
  - Arbitration uses pending & ~irq_mask, so single-cycle pulses, including ones arriving while in HANDLER, are not lost.
  - The acknowledged bit is cleared on irq_ack. Reset clears pending.
- **Undefined:** purely level-sensitive as above. Pulses not seen in IDLE with wb_valid are dropped.

Decomposition:
- Package wb_exc_pkg contains:
  - state typedef/encoding;
  - CAUSE_NONE = 3'b100 and CAUSE_SYSCALL = 3'b000;
  - OPCODE_ERET = 6'b010000, alongside the existing OPCODE_LW in opcodes.vh.
- Sub-module irq_priority_enc (N_IRQ-wide masked fixed-priority encoder): outputs valid, index, one-hot.

Test Plan:
- **LW select:** opcode=OPCODE_LW -> mux_rf_wd_select=1. Any other opcode -> 0. Holds in every FSM state.
- **Exception take and return:**
  - Stimulus: wb_cause=3'b010, wb_pc=0x0020, valid.
  - Next cycle: flush=1, redirect_addr=0x0004, epc=0x0020, cause_reg=4'b0010.
  - Then in_handler=1.
  - ERET -> redirect_addr=0x0021, then IDLE.
- **Priority and duplicate suppression:**
  - Exception plus irq_req=4'b0110 in the same cycle -> exception taken, irq_ack=0.
  - With irq_req held and only line 1 unmasked, after return -> line 1 taken, irq_ack=4'b0010, cause_reg=4'b1001, return to epc unchanged.
  - Repeat of the faulting wb_pc with a non-SYSCALL cause -> no take.
- **MIN_EPC boundary:** wb_pc=4 with a cause -> ignored. wb_pc=5 -> taken.
- **Reset mid-handler:** reset in HANDLER -> next cycle IDLE, epc=0, outputs 0. No RETURN redirect.
- **Pending latch (macro defined):** 1-cycle pulse on irq_req[3] during HANDLER -> taken right after RETURN. With the macro undefined -> never taken.

Source files
------------

// File: rtl/wb_exc_pkg.sv
// Shared encodings for the writeback exception unit: FSM states, cause codes and opcodes.
package wb_exc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } wb_state_e;

    localparam logic [2:0] CAUSE_NONE    = 3'b100;
    localparam logic [2:0] CAUSE_SYSCALL = 3'b000;

    localparam logic [5:0] OPCODE_LW   = 6'b100011;
    localparam logic [5:0] OPCODE_ERET = 6'b010000;

    // Index width for an n-entry one-hot vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Masked fixed-priority encoder: the lowest-index unmasked request wins.
module irq_priority_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    logic [N-1:0] eligible;

    always_comb begin
        eligible = req & ~mask;
        valid    = |eligible;
        // Two's-complement trick isolates the lowest set bit.
        onehot   = eligible & (~eligible + N'(1));
        idx      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_exception_unit.sv
// Writeback-stage controller: RF write-data select plus exception/interrupt sequencing.
// Optional macro WB_IRQ_PENDING_LATCH_EN latches irq pulses until acknowledged.
module wb_exception_unit
    import wb_exc_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int CAUSE_W     = 3,
    parameter int N_IRQ       = 4,
    parameter int MIN_EPC     = 5,
    parameter int VECTOR_ADDR = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_valid,
    input  logic [5:0]         opcode,
    input  logic [ADDR_W-1:0]  wb_pc,
    input  logic [CAUSE_W-1:0] wb_cause,
    input  logic [N_IRQ-1:0]   irq_req,
    input  logic [N_IRQ-1:0]   irq_mask,
    output logic               mux_rf_wd_select,
    output logic               flush,
    output logic               pc_redirect,
    output logic [ADDR_W-1:0]  redirect_addr,
    output logic [ADDR_W-1:0]  epc,
    output logic [CAUSE_W:0]   cause_reg,
    output logic               in_handler,
    output logic [N_IRQ-1:0]   irq_ack
);

    localparam int IDX_W = idx_width(N_IRQ);

    wb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  epc_q, epc_d;
    logic [CAUSE_W:0]   cause_q, cause_d;
    logic [N_IRQ-1:0]   ack_q, ack_d;
    logic [N_IRQ-1:0]   irq_src;

    logic               enc_valid;
    logic [IDX_W-1:0]   enc_idx;
    logic [N_IRQ-1:0]   enc_onehot;

    logic               pc_ok;
    logic               exc_ev;
    logic               irq_ev;

`ifdef WB_IRQ_PENDING_LATCH_EN
    logic [N_IRQ-1:0]   pending_q, pending_d;

    always_comb begin
        irq_src   = pending_q;
        pending_d = (pending_q & ~ack_d) | irq_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end
`else
    always_comb begin
        irq_src = irq_req;
    end
`endif

    irq_priority_enc #(
        .N     (N_IRQ),
        .IDX_W (IDX_W)
    ) u_irq_enc (
        .req    (irq_src),
        .mask   (irq_mask),
        .valid  (enc_valid),
        .idx    (enc_idx),
        .onehot (enc_onehot)
    );

    assign mux_rf_wd_select = (opcode == OPCODE_LW);

    // SYSCALL re-entry from the same PC is legitimate, so it skips duplicate suppression.
    always_comb begin
        pc_ok  = (wb_pc >= ADDR_W'(MIN_EPC));
        exc_ev = wb_valid && (wb_cause != CAUSE_W'(CAUSE_NONE)) && pc_ok &&
                 ((wb_pc != epc_q) || (wb_cause == CAUSE_W'(CAUSE_SYSCALL)));
        irq_ev = wb_valid && enc_valid && pc_ok;
    end

    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        ack_d         = '0;
        flush         = 1'b0;
        pc_redirect   = 1'b0;
        redirect_addr = '0;
        in_handler    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exc_ev) begin
                    epc_d   = wb_pc;
                    cause_d = {1'b0, wb_cause};
                    state_d = ST_FLUSH;
                end else if (irq_ev) begin
                    epc_d   = wb_pc;
                    cause_d = {1'b1, CAUSE_W'(enc_idx)};
                    ack_d   = enc_onehot;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush         = 1'b1;
                pc_redirect   = 1'b1;
                redirect_addr = ADDR_W'(VECTOR_ADDR);
                state_d       = ST_HANDLER;
            end
            ST_HANDLER: begin
                in_handler = 1'b1;
                if (wb_valid && (opcode == OPCODE_ERET)) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                flush         = 1'b1;
                pc_redirect   = 1'b1;
                // Interrupts resume the interrupted instruction; exceptions skip the faulting one.
                redirect_addr = cause_q[CAUSE_W] ? epc_q : (epc_q + ADDR_W'(1));
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            ack_q   <= ack_d;
        end
    end

    assign epc       = epc_q;
    assign cause_reg = cause_q;
    assign irq_ack   = ack_q;

endmodule

// File: tb/tb_wb_exception_unit.sv
// Directed scoreboard bench for wb_exception_unit (default parameters).
module tb_wb_exception_unit;
    import wb_exc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [5:0]  opcode;
    logic [15:0] wb_pc;
    logic [2:0]  wb_cause;
    logic [3:0]  irq_req;
    logic [3:0]  irq_mask;
    logic        mux_rf_wd_select;
    logic        flush;
    logic        pc_redirect;
    logic [15:0] redirect_addr;
    logic [15:0] epc;
    logic [3:0]  cause_reg;
    logic        in_handler;
    logic [3:0]  irq_ack;

    typedef struct packed {
        logic        flush;
        logic        pcr;
        logic [15:0] raddr;
        logic [15:0] epc;
        logic [3:0]  cause;
        logic        inh;
        logic [3:0]  ack;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } sb_t;

    sb_t sbq[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    wb_exception_unit dut (
        .clk              (clk),
        .reset            (reset),
        .wb_valid         (wb_valid),
        .opcode           (opcode),
        .wb_pc            (wb_pc),
        .wb_cause         (wb_cause),
        .irq_req          (irq_req),
        .irq_mask         (irq_mask),
        .mux_rf_wd_select (mux_rf_wd_select),
        .flush            (flush),
        .pc_redirect      (pc_redirect),
        .redirect_addr    (redirect_addr),
        .epc              (epc),
        .cause_reg        (cause_reg),
        .in_handler       (in_handler),
        .irq_ack          (irq_ack)
    );

    task automatic drive(input logic v, input logic [5:0] op, input logic [15:0] pc,
                         input logic [2:0] c);
        wb_valid = v;
        opcode   = op;
        wb_pc    = pc;
        wb_cause = c;
    endtask

    task automatic expect_out(input string tag, input logic f, input logic p,
                              input logic [15:0] ra, input logic [15:0] e,
                              input logic [3:0] c, input logic h, input logic [3:0] a);
        sb_t s;
        s.tag = tag;
        s.v   = {f, p, ra, e, c, h, a};
        sbq.push_back(s);
    endtask

    task automatic tick();
        sb_t  s;
        obs_t o;
        @(posedge clk);
        #1;
        o = {flush, pc_redirect, redirect_addr, epc, cause_reg, in_handler, irq_ack};
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: observed %h with nothing expected", o);
        end else begin
            s = sbq.pop_front();
            total++;
            assert (o === s.v) else begin
                bad++;
                $error("FAIL %s: got flush=%0b pcr=%0b raddr=%h epc=%h cause=%b inh=%0b ack=%b; want flush=%0b pcr=%0b raddr=%h epc=%h cause=%b inh=%0b ack=%b",
                       s.tag, o.flush, o.pcr, o.raddr, o.epc, o.cause, o.inh, o.ack,
                       s.v.flush, s.v.pcr, s.v.raddr, s.v.epc, s.v.cause, s.v.inh, s.v.ack);
            end
        end
    endtask

    task automatic check_sel(input string tag, input logic exp);
        #1;
        total++;
        assert (mux_rf_wd_select === exp) else begin
            bad++;
            $error("FAIL %s: got mux_rf_wd_select=%0b want %0b", tag, mux_rf_wd_select, exp);
        end
    endtask

    // Called while the DUT sits in FLUSH: walks HANDLER -> RETURN -> IDLE.
    task automatic handler_return(input string tag, input logic [15:0] e,
                                  input logic [3:0] c, input logic [15:0] ra);
        drive(1'b0, 6'h00, 16'h0000, CAUSE_NONE);
        expect_out({tag, "_handler"}, 1'b0, 1'b0, 16'h0000, e, c, 1'b1, 4'b0000);
        tick();
        drive(1'b1, OPCODE_ERET, e, CAUSE_NONE);
        expect_out({tag, "_return"}, 1'b1, 1'b1, ra, e, c, 1'b0, 4'b0000);
        tick();
        drive(1'b0, 6'h00, 16'h0000, CAUSE_NONE);
        expect_out({tag, "_idle"}, 1'b0, 1'b0, 16'h0000, e, c, 1'b0, 4'b0000);
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        irq_req  = 4'b0000;
        irq_mask = 4'b0000;
        drive(1'b0, 6'h00, 16'h0000, CAUSE_NONE);
        expect_out("reset", 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b0, 4'b0000);
        tick();
        reset = 1'b0;

        drive(1'b0, OPCODE_LW, 16'h0000, CAUSE_NONE);
        check_sel("lw_idle", 1'b1);
        drive(1'b0, 6'h01, 16'h0000, CAUSE_NONE);
        check_sel("nonlw_idle", 1'b0);

        drive(1'b1, 6'h00, 16'h0000, 3'b010);
        expect_out("pc0_supp", 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b0, 4'b0000);
        tick();

        // exception take, no nesting, event during ERET and RETURN ignored
        drive(1'b1, 6'h00, 16'h0020, 3'b010);
        expect_out("exc_flush", 1'b1, 1'b1, 16'h0004, 16'h0020, 4'b0010, 1'b0, 4'b0000);
        tick();
        drive(1'b0, OPCODE_LW, 16'h0000, CAUSE_NONE);
        check_sel("lw_flush", 1'b1);
        drive(1'b0, 6'h00, 16'h0000, CAUSE_NONE);
        expect_out("exc_handler", 1'b0, 1'b0, 16'h0000, 16'h0020, 4'b0010, 1'b1, 4'b0000);
        tick();
        drive(1'b1, OPCODE_LW, 16'h0030, 3'b001);
        check_sel("lw_handler", 1'b1);
        expect_out("handler_nonest", 1'b0, 1'b0, 16'h0000, 16'h0020, 4'b0010, 1'b1, 4'b0000);
        tick();
        drive(1'b1, OPCODE_ERET, 16'h0040, 3'b011);
        expect_out("exc_return", 1'b1, 1'b1, 16'h0021, 16'h0020, 4'b0010, 1'b0, 4'b0000);
        tick();
        drive(1'b1, 6'h00, 16'h0041, 3'b011);
        check_sel("nonlw_return", 1'b0);
        expect_out("return_ignore", 1'b0, 1'b0, 16'h0000, 16'h0020, 4'b0010, 1'b0, 4'b0000);
        tick();

        drive(1'b1, 6'h00, 16'h0020, 3'b010);
        expect_out("dup_supp", 1'b0, 1'b0, 16'h0000, 16'h0020, 4'b0010, 1'b0, 4'b0000);
        tick();

        // exception beats interrupt, then held irq on line 1 taken after return
        irq_req = 4'b0110;
        drive(1'b1, 6'h00, 16'h0050, 3'b011);
        expect_out("prio_exc", 1'b1, 1'b1, 16'h0004, 16'h0050, 4'b0011, 1'b0, 4'b0000);
        tick();
        irq_mask = 4'b1101;
        handler_return("prio", 16'h0050, 4'b0011, 16'h0051);
        drive(1'b1, 6'h00, 16'h0060, CAUSE_NONE);
        expect_out("irq_take", 1'b1, 1'b1, 16'h0004, 16'h0060, 4'b1001, 1'b0, 4'b0010);
        tick();
        irq_req = 4'b0000;
        handler_return("irq", 16'h0060, 4'b1001, 16'h0060);

        irq_mask = 4'b1111;
        drive(1'b1, 6'h00, 16'h0004, 3'b010);
        expect_out("min_epc_below", 1'b0, 1'b0, 16'h0000, 16'h0060, 4'b1001, 1'b0, 4'b0000);
        tick();
        drive(1'b1, 6'h00, 16'h0005, 3'b010);
        expect_out("min_epc_at", 1'b1, 1'b1, 16'h0004, 16'h0005, 4'b0010, 1'b0, 4'b0000);
        tick();

        // reset while in HANDLER abandons the return
        drive(1'b0, 6'h00, 16'h0000, CAUSE_NONE);
        expect_out("rst_pre", 1'b0, 1'b0, 16'h0000, 16'h0005, 4'b0010, 1'b1, 4'b0000);
        tick();
        reset = 1'b1;
        drive(1'b1, OPCODE_ERET, 16'h0005, CAUSE_NONE);
        expect_out("rst_mid", 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b0, 4'b0000);
        tick();
        reset = 1'b0;
        drive(1'b0, 6'h00, 16'h0000, CAUSE_NONE);
        expect_out("rst_no_return", 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b0, 4'b0000);
        tick();
        irq_mask = 4'b0000;

        drive(1'b1, 6'h00, 16'h0070, 3'b010);
        expect_out("sc_first", 1'b1, 1'b1, 16'h0004, 16'h0070, 4'b0010, 1'b0, 4'b0000);
        tick();
        handler_return("sc_first", 16'h0070, 4'b0010, 16'h0071);
        drive(1'b1, 6'h00, 16'h0070, CAUSE_SYSCALL);
        expect_out("sc_bypass", 1'b1, 1'b1, 16'h0004, 16'h0070, 4'b0000, 1'b0, 4'b0000);
        tick();
        handler_return("sc_bypass", 16'h0070, 4'b0000, 16'h0071);

        drive(1'b1, 6'h00, 16'hFFFF, 3'b101);
        expect_out("wrap_flush", 1'b1, 1'b1, 16'h0004, 16'hFFFF, 4'b0101, 1'b0, 4'b0000);
        tick();
        handler_return("wrap", 16'hFFFF, 4'b0101, 16'h0000);

        // one-cycle irq pulse on line 3 while in HANDLER
        drive(1'b1, 6'h00, 16'h0080, 3'b010);
        expect_out("pend_flush", 1'b1, 1'b1, 16'h0004, 16'h0080, 4'b0010, 1'b0, 4'b0000);
        tick();
        irq_req = 4'b1000;
        drive(1'b0, 6'h00, 16'h0000, CAUSE_NONE);
        expect_out("pend_handler", 1'b0, 1'b0, 16'h0000, 16'h0080, 4'b0010, 1'b1, 4'b0000);
        tick();
        irq_req = 4'b0000;
        drive(1'b1, OPCODE_ERET, 16'h0081, CAUSE_NONE);
        expect_out("pend_return", 1'b1, 1'b1, 16'h0081, 16'h0080, 4'b0010, 1'b0, 4'b0000);
        tick();
        drive(1'b1, 6'h00, 16'h0090, CAUSE_NONE);
        expect_out("pend_idle", 1'b0, 1'b0, 16'h0000, 16'h0080, 4'b0010, 1'b0, 4'b0000);
        tick();
        drive(1'b1, 6'h00, 16'h0090, CAUSE_NONE);
`ifdef WB_IRQ_PENDING_LATCH_EN
        expect_out("pend_take", 1'b1, 1'b1, 16'h0004, 16'h0090, 4'b1011, 1'b0, 4'b1000);
        tick();
        handler_return("pend", 16'h0090, 4'b1011, 16'h0090);
`else
        expect_out("pend_drop", 1'b0, 1'b0, 16'h0000, 16'h0080, 4'b0010, 1'b0, 4'b0000);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
